tnn_test_sequencer: RTL and testbench



---
 rtl/tnn_pkg.sv | 20 ++
 rtl/tnn_cycle_timer.sv | 32 +++
 rtl/tnn_test_sequencer.sv | 158 +++++++++++++++
 tb/tb_tnn_test_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tnn_pkg.sv
// Shared definitions for the tnndirect self-test slice.
//   tnn_state_e  : test sequencer FSM states
//   tnn_latency  : classifier latency in cycles (features shifted in, then hidden layer)
//   tnn_width    : bits needed to hold values 0..n-1, never below 1
package tnn_pkg;

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, RSTP, RUN, REPORT, DONE
  } tnn_state_e;

  function automatic int tnn_latency(input int feat, input int hidden);
    return feat + hidden;
  endfunction

  // A one-value range still needs a 1-bit port.
  function automatic int tnn_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tnn_cycle_timer.sv
// Loadable down-counter that times the classifier run window.
//   clk, rst : clock, synchronous active-high reset
//   load     : load LAT-1; the counter then reaches 0 on the LAT-th cycle
//   expire   : counter is at 0 (meaningful only after a load)
module tnn_cycle_timer
  import tnn_pkg::*;
#(
  parameter int LAT = 52,
  parameter int TW  = tnn_width(LAT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)               cnt_d = TW'(LAT - 1);
    else if (cnt_q != '0)   cnt_d = cnt_q - TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/tnn_test_sequencer.sv
// On-chip self-test driver for a tnndirect classifier.
// Walks the test ROM, drives each feature vector into the classifier after a
// one-cycle classifier reset, waits the fixed latency, scores the prediction
// against the golden label and offers the result on a valid/ready stream.
//   clk, rst          : clock, synchronous active-high reset
//   start             : pulse, begins a run from IDLE or DONE
//   tc_addr           : ROM address; tc_data/tc_label arrive one cycle later
//   dut_data, dut_rst : registered classifier drive
//   dut_prediction    : classifier output, sampled at the end of the run window
//   res_*             : result stream (valid/ready), held while stalled
//   correct_cnt       : accepted correct results this run
//   busy, done        : run in progress / run complete
module tnn_test_sequencer
  import tnn_pkg::*;
#(
  parameter int FEAT_CNT   = 12,
  parameter int HIDDEN_CNT = 40,
  parameter int FEAT_BITS  = 4,
  parameter int CLASS_CNT  = 6,
  parameter int TEST_CNT   = 1000,
  parameter int LAT        = tnn_latency(FEAT_CNT, HIDDEN_CNT),
  parameter int AW         = tnn_width(TEST_CNT),
  parameter int PW         = tnn_width(CLASS_CNT),
  parameter int CW         = tnn_width(TEST_CNT + 1),
  parameter int DW         = FEAT_BITS * FEAT_CNT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] tc_addr,
  input  logic [DW-1:0] tc_data,
  input  logic [PW-1:0] tc_label,
  output logic [DW-1:0] dut_data,
  output logic          dut_rst,
  input  logic [PW-1:0] dut_prediction,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [AW-1:0] res_index,
  output logic [PW-1:0] res_pred,
  output logic          res_correct,
  output logic [CW-1:0] correct_cnt,
  output logic          busy,
  output logic          done
);

  tnn_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] dut_data_q, dut_data_d;
  logic [PW-1:0] label_q, label_d;
  logic          dut_rst_q, dut_rst_d;
  logic          res_valid_q, res_valid_d;
  logic [AW-1:0] res_index_q, res_index_d;
  logic [PW-1:0] res_pred_q, res_pred_d;
  logic          res_correct_q, res_correct_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmr_load, tmr_expire;

  // Loaded in RSTP so it hits zero on the last of the LAT RUN cycles.
  assign tmr_load = (state_q == RSTP);

  tnn_cycle_timer #(.LAT(LAT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    dut_data_d    = dut_data_q;
    label_d       = label_q;
    res_valid_d   = res_valid_q;
    res_index_d   = res_index_q;
    res_pred_d    = res_pred_q;
    res_correct_d = res_correct_q;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        dut_data_d = tc_data;
        label_d    = tc_label;
        state_d    = RSTP;
      end
      RSTP: state_d = RUN;
      RUN: begin
        if (tmr_expire) begin
          res_pred_d    = dut_prediction;
          res_correct_d = (dut_prediction == label_q);
          res_index_d   = idx_q;
          res_valid_d   = 1'b1;
          state_d       = REPORT;
        end
      end
      REPORT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          cnt_d       = cnt_q + CW'(res_correct_q);
          if (idx_q == AW'(TEST_CNT - 1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered from the next state so dut_rst lines up with the state it belongs to;
    // the classifier is only released while running or holding a result.
    dut_rst_d = !((state_d == RUN) || (state_d == REPORT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      dut_data_q    <= '0;
      label_q       <= '0;
      dut_rst_q     <= 1'b1;
      res_valid_q   <= 1'b0;
      res_index_q   <= '0;
      res_pred_q    <= '0;
      res_correct_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      dut_data_q    <= dut_data_d;
      label_q       <= label_d;
      dut_rst_q     <= dut_rst_d;
      res_valid_q   <= res_valid_d;
      res_index_q   <= res_index_d;
      res_pred_q    <= res_pred_d;
      res_correct_q <= res_correct_d;
      cnt_q         <= cnt_d;
    end
  end

  assign tc_addr     = idx_q;
  assign dut_data    = dut_data_q;
  assign dut_rst     = dut_rst_q;
  assign res_valid   = res_valid_q;
  assign res_index   = res_index_q;
  assign res_pred    = res_pred_q;
  assign res_correct = res_correct_q;
  assign correct_cnt = cnt_q;
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_tnn_test_sequencer.sv
// Bench for tnn_test_sequencer with a 3-case ROM and a latency-accurate
// classifier stand-in. A timeline model (case index + cycles since the case
// began) predicts every output each cycle; directed checks pin key literals.
module tb_tnn_test_sequencer;

  localparam int TN  = 3;
  localparam int LAT = 52;
  localparam int AW  = 2;
  localparam int PW  = 3;
  localparam int CW  = 2;
  localparam int DW  = 48;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          res_ready = 1'b1;
  logic [AW-1:0] tc_addr;
  logic [DW-1:0] tc_data = '0;
  logic [PW-1:0] tc_label = '0;
  logic [DW-1:0] dut_data;
  logic          dut_rst;
  logic [PW-1:0] dut_prediction;
  logic          res_valid;
  logic [AW-1:0] res_index;
  logic [PW-1:0] res_pred;
  logic          res_correct;
  logic [CW-1:0] correct_cnt;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  tnn_test_sequencer #(.TEST_CNT(TN)) dut (
    .clk(clk), .rst(rst), .start(start), .tc_addr(tc_addr), .tc_data(tc_data),
    .tc_label(tc_label), .dut_data(dut_data), .dut_rst(dut_rst),
    .dut_prediction(dut_prediction), .res_valid(res_valid), .res_ready(res_ready),
    .res_index(res_index), .res_pred(res_pred), .res_correct(res_correct),
    .correct_cnt(correct_cnt), .busy(busy), .done(done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Test ROM: low byte of each feature word is the case index so the
  // classifier stand-in can tell which vector it was given.
  logic [DW-1:0] rom_data [TN];
  logic [PW-1:0] rom_label[TN];
  logic [TN-1:0] wrong = 3'b010;

  initial begin
    rom_data[0] = 48'h1234_5678_9A00;  rom_label[0] = 3'd2;
    rom_data[1] = 48'hFEDC_BA98_7601;  rom_label[1] = 3'd5;
    rom_data[2] = 48'h0F0F_A5A5_3C02;  rom_label[2] = 3'd0;
  end

  always @(posedge clk) begin
    tc_data  <= rom_data[tc_addr];
    tc_label <= rom_label[tc_addr];
  end

  // Classifier answer for case k: the label, or the next class when marked wrong.
  function automatic logic [PW-1:0] cls(input int k);
    int v;
    v = int'(rom_label[k]);
    if (wrong[k]) v = (v + 1) % 6;
    return PW'(v);
  endfunction

  // Prediction is only valid once dut_rst has been low for exactly LAT-1
  // edges; any other sample sees the out-of-range class 7.
  int run_cyc = 0;
  always @(posedge clk) run_cyc <= dut_rst ? 0 : run_cyc + 1;

  always_comb begin
    dut_prediction = 3'd7;
    if (run_cyc == LAT - 1 && int'(dut_data[7:0]) < TN)
      dut_prediction = cls(int'(dut_data[7:0]));
  end

  // Timeline model: mode 0 idle, 1 running, 2 done. t = cycles since the
  // current case began; 0 fetch, 1 latch, 2 classifier reset, 3..LAT+2 run,
  // LAT+3 result offered.
  int m_mode = 0, m_k = 0, m_t = 0, m_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_k = 0; m_t = 0; m_cnt = 0;
    end else if (m_mode != 1) begin
      if (start) begin m_mode = 1; m_k = 0; m_t = 0; m_cnt = 0; end
    end else if (m_t < LAT + 3) begin
      m_t++;
    end else if (res_ready) begin
      m_cnt += wrong[m_k] ? 0 : 1;
      if (m_k == TN - 1) m_mode = 2;
      else begin m_k++; m_t = 0; end
    end
  end

  always @(negedge clk) begin
    chk("busy",        64'(busy),        64'(m_mode == 1));
    chk("done",        64'(done),        64'(m_mode == 2));
    chk("dut_rst",     64'(dut_rst),     64'(!(m_mode == 1 && m_t >= 3)));
    chk("res_valid",   64'(res_valid),   64'(m_mode == 1 && m_t == LAT + 3));
    chk("correct_cnt", 64'(correct_cnt), 64'(m_cnt));
    if (m_mode == 1 && m_t == 0) chk("tc_addr", 64'(tc_addr), 64'(m_k));
    if (m_mode == 1 && m_t >= 3) chk("dut_data", 64'(dut_data), 64'(rom_data[m_k]));
    if (m_mode == 1 && m_t == LAT + 3) begin
      chk("res_index",   64'(res_index),   64'(m_k));
      chk("res_pred",    64'(res_pred),    64'(cls(m_k)));
      chk("res_correct", 64'(res_correct), 64'(!wrong[m_k]));
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!res_valid && n < 200) begin @(negedge clk); n++; end
    chk(name, 64'(res_valid), 64'(1));
  endtask

  // Runs to DONE, recording res_correct of each accepted result.
  task automatic wait_done(input string name, output logic [TN-1:0] bits);
    int n, nacc;
    n = 0; nacc = 0; bits = '0;
    while (!done && n < 1000) begin
      if (res_valid && res_ready && nacc < TN) begin bits[nacc] = res_correct; nacc++; end
      @(negedge clk); n++;
    end
    chk(name, 64'(done), 64'(1));
  endtask

  initial begin
    int n;
    logic [TN-1:0] bits;
    rst = 1'b1; start = 1'b0; res_ready = 1'b1; wrong = 3'b010;
    repeat (3) @(negedge clk);
    chk("rst_tc_addr",     64'(tc_addr),     64'(0));
    chk("rst_dut_data",    64'(dut_data),    64'(0));
    chk("rst_dut_rst",     64'(dut_rst),     64'(1));
    chk("rst_res_valid",   64'(res_valid),   64'(0));
    chk("rst_res_index",   64'(res_index),   64'(0));
    chk("rst_res_pred",    64'(res_pred),    64'(0));
    chk("rst_res_correct", 64'(res_correct), 64'(0));
    chk("rst_correct_cnt", 64'(correct_cnt), 64'(0));
    chk("rst_busy",        64'(busy),        64'(0));
    chk("rst_done",        64'(done),        64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Run 1: case 1 misclassified, stray start pulse in RUN.
    pulse_start();
    n = 0;
    while (!res_valid && n < 200) begin
      start = (n == 20);
      @(negedge clk); n++;
    end
    start = 1'b0;
    chk("first_latency", 64'(n),           64'(55));
    chk("first_index",   64'(res_index),   64'(0));
    chk("first_correct", 64'(res_correct), 64'(1));
    wait_done("run1_done", bits);
    chk("run1_seq", 64'(bits),        64'(3'b101));
    chk("run1_cnt", 64'(correct_cnt), 64'(2));

    // Run 2 from DONE with 20 cycles of backpressure on case 0.
    wrong = 3'b000; res_ready = 1'b0;
    pulse_start();
    chk("restart_cnt",  64'(correct_cnt), 64'(0));
    chk("restart_addr", 64'(tc_addr),     64'(0));
    wait_valid("run2_valid");
    repeat (20) @(negedge clk);
    chk("stall_valid",  64'(res_valid),   64'(1));
    chk("stall_rst",    64'(dut_rst),     64'(0));
    chk("stall_cnt",    64'(correct_cnt), 64'(0));
    chk("stall_data",   64'(dut_data),    64'(48'h1234_5678_9A00));
    chk("stall_pred",   64'(res_pred),    64'(2));
    res_ready = 1'b1;
    @(negedge clk);
    chk("accept_cnt",   64'(correct_cnt), 64'(1));
    chk("accept_valid", 64'(res_valid),   64'(0));
    wait_done("run2_done", bits);
    chk("run2_cnt", 64'(correct_cnt), 64'(3));

    // Run 3: reset during RUN of case 1, then rst+start together, then rerun.
    wrong = 3'b100;
    pulse_start();
    wait_valid("run3_valid");
    @(negedge clk);
    repeat (10) @(negedge clk);
    chk("pre_abort_cnt",  64'(correct_cnt), 64'(1));
    chk("pre_abort_rst",  64'(dut_rst),     64'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy",  64'(busy),        64'(0));
    chk("abort_rst",   64'(dut_rst),     64'(1));
    chk("abort_valid", 64'(res_valid),   64'(0));
    chk("abort_cnt",   64'(correct_cnt), 64'(0));
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_wins_busy", 64'(busy), 64'(0));
    @(negedge clk);
    pulse_start();
    chk("resume_addr", 64'(tc_addr), 64'(0));
    chk("resume_busy", 64'(busy),    64'(1));
    wait_done("run3_done", bits);
    chk("run3_seq", 64'(bits),        64'(3'b011));
    chk("run3_cnt", 64'(correct_cnt), 64'(2));

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
